// File: rtl/imem_loader.sv
// imem_loader: streams machine-code words into instruction memory,
// halt-fills the unused tail and holds the CPU in reset until done.
module imem_loader #(
   parameter int             AW        = 16,
   parameter int             IW        = 9,
   parameter int             MAX_WORDS = 256,
   parameter logic [IW-1:0]  HALT_WORD = 9'b111_111_111,
   parameter bit             FILL_EN   = 1'b1
) (
   input  logic          CLK,
   input  logic          reset_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [IW-1:0] in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [IW-1:0] wr_data,
   output logic [AW:0]   word_count,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic          cpu_hold
);

   typedef enum logic [2:0] {
      IDLE, LOAD, FILL, DONE, ERR
   } state_t;

   localparam logic [AW-1:0] LAST  = AW'(MAX_WORDS - 1);
   localparam logic [AW-1:0] ONE_P = AW'(1);
   localparam logic [AW:0]   ONE_C = (AW+1)'(1);

   state_t        state, state_n;
   logic [AW-1:0] ptr, ptr_n;
   logic [AW:0]   cnt, cnt_n;
   logic          we_n;
   logic [AW-1:0] wa_n;
   logic [IW-1:0] wd_n;
   // fin marks that the final write strobe is on the bus; DONE follows
   // one edge later so the CPU is released only after that write lands.
   logic          fin, fin_n;

   // State, pointer, counters and the registered write port.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         ptr     <= '0;
         cnt     <= '0;
         fin     <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
         fin     <= fin_n;
         wr_en   <= we_n;
         wr_addr <= wa_n;
         wr_data <= wd_n;
      end
   end

   // Next-state, pointer advance and write command generation.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      cnt_n   = cnt;
      fin_n   = 1'b0;
      we_n    = 1'b0;
      wa_n    = wr_addr;
      wd_n    = wr_data;
      unique case (state)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_n = LOAD;
               ptr_n   = '0;
               cnt_n   = '0;
            end
         end
         LOAD: begin
            if (fin) begin
               state_n = DONE;
            end else if (in_valid) begin
               we_n  = 1'b1;
               wa_n  = ptr;
               wd_n  = in_data;
               cnt_n = cnt + ONE_C;
               if (in_last) begin
                  if (FILL_EN && ptr < LAST) begin
                     state_n = FILL;
                     ptr_n   = ptr + ONE_P;
                  end else begin
                     fin_n = 1'b1;
                  end
               end else if (ptr == LAST) begin
                  state_n = ERR;
               end else begin
                  ptr_n = ptr + ONE_P;
               end
            end
         end
         FILL: begin
            if (fin) begin
               state_n = DONE;
            end else begin
               we_n = 1'b1;
               wa_n = ptr;
               wd_n = HALT_WORD;
               if (ptr == LAST) fin_n = 1'b1;
               else ptr_n = ptr + ONE_P;
            end
         end
      endcase
   end

   assign in_ready   = (state == LOAD) && !fin;
   assign busy       = (state == LOAD) || (state == FILL);
   assign done       = (state == DONE);
   assign error      = (state == ERR);
   assign cpu_hold   = (state != DONE);
   assign word_count = cnt;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader, a fill-enabled
// and a fill-disabled instance sharing one input stream.
module tb_imem_loader;

   localparam int AW = 16;
   localparam int IW = 9;
   localparam int MW = 16;
   localparam logic [IW-1:0] HALT = 9'h1FF;

   logic          CLK = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [IW-1:0] in_data = '0;
   logic          in_last = 1'b0;

   logic          rdy0, we0, busy0, done0, err0, hold0;
   logic [AW-1:0] wa0;
   logic [IW-1:0] wd0;
   logic [AW:0]   wc0;
   logic          rdy1, we1, busy1, done1, err1, hold1;
   logic [AW-1:0] wa1;
   logic [IW-1:0] wd1;
   logic [AW:0]   wc1;

   imem_loader #(.AW(AW), .IW(IW), .MAX_WORDS(MW),
                 .HALT_WORD(HALT), .FILL_EN(1'b1)) u0 (
      .CLK(CLK), .reset_n(reset_n), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(rdy0), .wr_en(we0), .wr_addr(wa0), .wr_data(wd0),
      .word_count(wc0), .busy(busy0), .done(done0), .error(err0),
      .cpu_hold(hold0));

   imem_loader #(.AW(AW), .IW(IW), .MAX_WORDS(MW),
                 .HALT_WORD(HALT), .FILL_EN(1'b0)) u1 (
      .CLK(CLK), .reset_n(reset_n), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(rdy1), .wr_en(we1), .wr_addr(wa1), .wr_data(wd1),
      .word_count(wc1), .busy(busy1), .done(done1), .error(err1),
      .cpu_hold(hold1));

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last0   = 0;
   int last1   = 0;
   int done_cyc;
   bit en0 = 1'b0;
   bit en1 = 1'b0;
   logic [AW+IW-1:0] q0[$];
   logic [AW+IW-1:0] q1[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Scoreboard: pop and compare every write strobe that appears.
   always @(negedge CLK) begin
      if (reset_n && en0 && we0) begin
         if (q0.size() == 0) chk("wr0_extra", {wa0, wd0}, 32'hFFFF_FFFF);
         else chk("wr0", {wa0, wd0}, q0.pop_front());
         last0 = cyc;
      end
      if (reset_n && en1 && we1) begin
         if (q1.size() == 0) chk("wr1_extra", {wa1, wd1}, 32'hFFFF_FFFF);
         else chk("wr1", {wa1, wd1}, q1.pop_front());
         last1 = cyc;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic go();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic send(input logic [IW-1:0] d, input logic l);
      int b;
      logic r;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      b = 0;
      do begin
         @(negedge CLK);
         r = rdy0;
         @(posedge CLK);
         #1;
         b++;
      end while (!r && b < 50);
      if (!r) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input int which);
      int b;
      logic d;
      b = 0;
      d = 1'b0;
      while (!d && b < 100) begin
         @(negedge CLK);
         d = (which == 0) ? done0 : done1;
         b++;
      end
      done_cyc = cyc;
      if (!d) chk("done_timeout", 0, 1);
      step(1);
   endtask

   task automatic push_fill(input int from);
      for (int a = from; a < MW; a++) q0.push_back({AW'(a), HALT});
   endtask

   initial begin
      // Reset values while reset_n is held low.
      #3;
      chk("rst_wr_en", we0, 0);
      chk("rst_wr_addr", wa0, 0);
      chk("rst_wr_data", wd0, 0);
      chk("rst_count", wc0, 0);
      chk("rst_flags", {rdy0, busy0, done0, err0}, 0);
      chk("rst_hold", hold0, 1);
      #4 reset_n = 1'b1;
      step(1);

      // Basic load: 10 words then halt fill up to address 15.
      en0 = 1'b1;
      for (int i = 0; i < 10; i++) q0.push_back({AW'(i), IW'(i + 1)});
      push_fill(10);
      go();
      for (int i = 1; i <= 10; i++) send(IW'(i), i == 10);
      wait_done(0);
      chk("basic_done_lat", done_cyc - last0, 1);
      chk("basic_count", wc0, 10);
      chk("basic_hold", hold0, 0);
      chk("basic_q", q0.size(), 0);

      // Gaps: in_valid 1,0,0,1,0,1 keeps addresses contiguous.
      q0.push_back({AW'(0), 9'h0A5});
      q0.push_back({AW'(1), 9'h05A});
      q0.push_back({AW'(2), 9'h133});
      push_fill(3);
      go();
      send(9'h0A5, 1'b0);
      step(2);
      send(9'h05A, 1'b0);
      step(1);
      send(9'h133, 1'b1);
      wait_done(0);
      chk("gap_count", wc0, 3);
      chk("gap_q", q0.size(), 0);
      step(2);

      // Overflow: 16 words without last, the 17th is refused.
      for (int i = 0; i < MW; i++) q0.push_back({AW'(i), IW'(9'h100 + i)});
      go();
      for (int i = 0; i < MW; i++) send(IW'(9'h100 + i), 1'b0);
      in_valid = 1'b1;
      in_data  = 9'h1EE;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("ovf_ready", rdy0, 0);
      end
      step(1);
      in_valid = 1'b0;
      chk("ovf_error", err0, 1);
      chk("ovf_count", wc0, MW);
      chk("ovf_hold", hold0, 1);
      chk("ovf_q", q0.size(), 0);

      // Exact fit: last on the 16th word, no halt fill.
      for (int i = 0; i < MW; i++) q0.push_back({AW'(i), IW'(9'h040 + i)});
      go();
      for (int i = 0; i < MW; i++) send(IW'(9'h040 + i), i == MW - 1);
      wait_done(0);
      chk("fit_done_lat", done_cyc - last0, 1);
      chk("fit_count", wc0, MW);
      chk("fit_q", q0.size(), 0);
      wait_done(1);

      // No-fill instance: 3 words then straight to DONE.
      en0 = 1'b0;
      en1 = 1'b1;
      for (int i = 0; i < 3; i++) q1.push_back({AW'(i), IW'(9'h0C0 + i)});
      go();
      for (int i = 0; i < 3; i++) send(IW'(9'h0C0 + i), i == 2);
      wait_done(1);
      chk("nofill_done_lat", done_cyc - last1, 1);
      chk("nofill_count", wc1, 3);
      chk("nofill_q", q1.size(), 0);
      en1 = 1'b0;
      wait_done(0);

      // Abort: asynchronous reset in the middle of FILL.
      go();
      for (int i = 0; i < 3; i++) send(IW'(i), i == 2);
      step(2);
      @(negedge CLK);
      chk("abort_in_fill", {busy0, rdy0}, 2'b10);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_state", {busy0, done0, err0, rdy0, we0}, 0);
      chk("abort_count", wc0, 0);
      chk("abort_hold", hold0, 1);
      #3 reset_n = 1'b1;
      step(1);

      // Restart: load to DONE, then a fresh load from DONE.
      en0 = 1'b1;
      q0.push_back({AW'(0), 9'h011});
      q0.push_back({AW'(1), 9'h022});
      push_fill(2);
      go();
      send(9'h011, 1'b0);
      send(9'h022, 1'b1);
      wait_done(0);
      chk("rs1_count", wc0, 2);
      q0.push_back({AW'(0), 9'h0F0});
      q0.push_back({AW'(1), 9'h00F});
      push_fill(2);
      go();
      @(negedge CLK);
      chk("rs2_clear", wc0, 0);
      chk("rs2_busy", busy0, 1);
      step(1);
      send(9'h0F0, 1'b0);
      send(9'h00F, 1'b1);
      wait_done(0);
      chk("rs2_count", wc0, 2);
      chk("rs2_q", q0.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer-side counterpart to the instruction memory ROM. It accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them to consecutive instruction-memory addresses starting at 0. After the last word it fills the unused locations with the halt word, so any unloaded PC fetches a halt. It holds the CPU in reset until the program image is complete, which replaces file-based ROM initialisation for on-board and bench loading.

## Interface
Parameters:
- AW, 16: address width; matches the PC width.
- IW, 9: instruction word width.
- MAX_WORDS, 256: number of imem locations the loader owns (addresses 0..MAX_WORDS-1); must be ≤ 2**AW.
- HALT_WORD, 9'b111_111_111: value written to unloaded locations.
- FILL_EN, 1: 1 = halt-fill after the last word; 0 = go straight to DONE.

Ports:
- CLK, input, 1: clock; all state changes on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begins a load when sampled high in IDLE, DONE or ERR.
- in_valid, input, 1: in_data and in_last are valid.
- in_data, input, IW: instruction word.
- in_last, input, 1: marks the final word of the image.
- in_ready, output, 1: loader accepts a word this cycle.
- wr_en, output, 1: imem write strobe.
- wr_addr, output, AW: imem write address.
- wr_data, output, IW: imem write data.
- word_count, output, AW+1: number of words accepted in the current or last load.
- busy, output, 1: high in LOAD or FILL.
- done, output, 1: high in DONE.
- error, output, 1: high in ERR (image overflow).
- cpu_hold, output, 1: holds the CPU in reset; low only in DONE.

## Operation
- States: IDLE, LOAD, FILL, DONE, ERR.
- Reset: state IDLE. wr_en=0, wr_addr=0, wr_data=0, word_count=0, busy=0, done=0, error=0, in_ready=0, cpu_hold=1.
- IDLE/DONE/ERR with start=1 → LOAD. On the same edge, the address pointer and word_count clear to 0.
- LOAD: in_ready=1. A transfer occurs on any edge where in_valid && in_ready.
  - Each transfer writes in_data to the pointer address, then increments the pointer and word_count.
  - Transfer with in_last=1 → FILL if FILL_EN && pointer < MAX_WORDS-1; otherwise → DONE.
  - Transfer at pointer = MAX_WORDS-1 with in_last=0 → ERR. That word is still written; word_count = MAX_WORDS.
- FILL: in_ready=0. Writes HALT_WORD to the pointer, one address per cycle, from word_count to MAX_WORDS-1. After the write to MAX_WORDS-1 → DONE. word_count is not changed.
- start while busy is ignored.
- in_valid outside LOAD is ignored; no transfer occurs.
- Pointer arithmetic: AW bits, never wraps. The ERR transition fires before the pointer can pass MAX_WORDS-1.
- An asynchronous reset mid-LOAD or mid-FILL aborts immediately to IDLE; partially written imem contents are not cleared.

## Timing
- in_ready, busy, done, error and cpu_hold are decoded only from the registered state; none depends combinationally on inputs.
- Write latency is 1 cycle. A transfer on edge k drives wr_en=1 with that word's wr_addr/wr_data for the cycle after edge k, and wr_en=0 the next cycle unless another transfer occurred.
- Full throughput is one word per cycle while in_valid stays high.
- FILL produces one write per cycle and takes MAX_WORDS − word_count cycles.
- done rises on the edge after the final write strobe is issued. cpu_hold falls on that same edge, so the CPU never fetches before the last write completes.
- ERR and DONE are held until start or reset.

## Test plan
- Reset: assert reset_n=0 mid-cycle → all outputs take their reset values immediately; cpu_hold=1.
- Basic load: MAX_WORDS=16, start, then 10 words 9'h001..9'h00A back-to-back, last on the 10th → wr_en on addresses 0..9 with matching data, then HALT_WORD on 10..15. done rises 1 cycle after the addr-15 write; word_count=10; cpu_hold=0.
- Backpressure/gaps: in_valid toggling 1,0,0,1 → writes only on accepted words; addresses stay contiguous; no write strobe in gap cycles.
- Overflow: MAX_WORDS=16, 17 words with no in_last → 16 writes (addr 0..15); error=1, word_count=16; the 17th word is not accepted.
- Exact fit and no-fill: 16 words with last on the 16th → DONE, no FILL cycles. Separately, FILL_EN=0 with 3 words → DONE right after the addr-2 write.
- Abort and restart: reset_n low during FILL → IDLE. Then start from DONE with a 2-word load → word_count restarts at 0; addresses begin at 0.
